// File: rtl/sector_read_serializer_if.sv
// Byte-fetch bus between the sector read serializer (master) and the sector buffer RAM (slave).
interface sector_read_serializer_if #(
    parameter int AW = 9
) ();
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_valid;

    modport master (output mem_req, output mem_addr, input mem_data, input mem_valid);
    modport slave  (input mem_req, input mem_addr, output mem_data, output mem_valid);
endinterface

// File: rtl/sector_read_serializer.sv
// Serializes one sector per strobe: address gap, header, data gap, buffered data bytes,
// optional checksum; fetches bytes one ahead through a single-entry buffer.
module sector_read_serializer #(
    parameter int HS_W          = 2,
    parameter int CYL_W         = 9,
    parameter int SECT_W        = 5,
    parameter int ADDR_GAP_BITS = 208,
    parameter int DATA_GAP_BITS = 208,
    parameter int DATA_BYTES    = 408,
    parameter bit CHK_EN        = 1'b1,
    parameter int CHK_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [HS_W-1:0]          hs,
    input  logic [CYL_W-1:0]         cyl,
    input  logic [SECT_W-1:0]        sect,
    input  logic                     sector_strobe,
    input  logic                     rd_en,
    sector_read_serializer_if.master mem,
    output logic                     data_out,
    output logic                     data_area,
    output logic                     prefetch,
    output logic                     underrun
);
    localparam int HDR_W    = HS_W + CYL_W + SECT_W;
    localparam int AW       = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int DATA_LEN = 8 * DATA_BYTES;
    localparam int M1       = (ADDR_GAP_BITS > DATA_GAP_BITS) ? ADDR_GAP_BITS : DATA_GAP_BITS;
    localparam int M2       = (M1 > DATA_LEN) ? M1 : DATA_LEN;
    localparam int M3       = (M2 > HDR_W) ? M2 : HDR_W;
    localparam int MAX_LEN  = (M3 > CHK_W) ? M3 : CHK_W;
    localparam int CW       = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {IDLE, ADDR_GAP, HDR, DATA_GAP, DATA, CHK, END_GAP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic [7:0]         byte_q, byte_d;
    logic [7:0]         buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic               pend_q, pend_d;
    logic [CHK_W-1:0]   chk_q, chk_d;
    logic               und_q, und_d;
    logic               dout_q, dout_d;
    logic               area_q, area_d;
    logic               pf_q, pf_d;
    logic               rd_en_q, rd_en_d;

    logic               bit_s, last, req;
    logic [AW-1:0]      req_addr;
    logic [7:0]         byte_now;
    logic [CW-1:0]      byte_idx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        byte_d     = byte_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        pend_d     = pend_q;
        chk_d      = chk_q;
        und_d      = und_q;
        bit_s      = 1'b0;
        last       = 1'b0;
        req        = 1'b0;
        req_addr   = '0;
        byte_now   = buf_full_q ? buf_q : 8'h00;
        byte_idx   = cnt_q >> 3;

        // Returns are accepted only against a live request; strays are dropped.
        if (mem.mem_valid && pend_q) begin
            buf_d      = mem.mem_data;
            buf_full_d = 1'b1;
            pend_d     = 1'b0;
        end

        unique case (state_q)
            ADDR_GAP: begin
                last  = (cnt_q == CW'(ADDR_GAP_BITS - 1));
                bit_s = last;
                if (last) begin
                    hdr_d   = {hs, cyl, sect};
                    state_d = HDR;
                end
            end
            HDR: begin
                last  = (cnt_q == CW'(HDR_W - 1));
                bit_s = hdr_q[0];
                hdr_d = hdr_q >> 1;
                if (last) state_d = DATA_GAP;
            end
            DATA_GAP: begin
                last  = (cnt_q == CW'(DATA_GAP_BITS - 1));
                bit_s = last;
                if (cnt_q == '0) req = 1'b1;
                if (last) state_d = DATA;
            end
            DATA: begin
                last = (cnt_q == CW'(DATA_LEN - 1));
                if (cnt_q[2:0] == 3'd0) begin
                    // An empty buffer here is an underrun: the byte goes out as zero.
                    bit_s      = byte_now[7];
                    byte_d     = {byte_now[6:0], 1'b0};
                    chk_d      = chk_q + CHK_W'(byte_now);
                    buf_full_d = 1'b0;
                    if (!buf_full_q) und_d = 1'b1;
                    if (byte_idx + CW'(1) < CW'(DATA_BYTES)) begin
                        req      = 1'b1;
                        req_addr = AW'(byte_idx + CW'(1));
                    end
                end else begin
                    bit_s  = byte_q[7];
                    byte_d = {byte_q[6:0], 1'b0};
                end
                if (last) state_d = CHK_EN ? CHK : END_GAP;
            end
            CHK: begin
                last  = (cnt_q == CW'(CHK_W - 1));
                bit_s = chk_q[CHK_W-1];
                chk_d = chk_q << 1;
                if (last) state_d = END_GAP;
            end
            default: ;
        endcase

        if (last)
            cnt_d = '0;
        else if (state_q != IDLE && state_q != END_GAP)
            cnt_d = cnt_q + CW'(1);

        if (req) pend_d = 1'b1;

        if (sector_strobe) begin
            state_d    = ADDR_GAP;
            cnt_d      = '0;
            und_d      = 1'b0;
            chk_d      = '0;
            buf_full_d = 1'b0;
            pend_d     = 1'b0;
            req        = 1'b0;
        end

        dout_d  = bit_s;
        area_d  = (state_q == DATA) || (state_q == CHK) || (state_q == END_GAP);
        pf_d    = rd_en && !rd_en_q &&
                  ((state_q == IDLE) || (state_q == ADDR_GAP) || (state_q == HDR));
        rd_en_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hdr_q      <= '0;
            byte_q     <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            pend_q     <= 1'b0;
            chk_q      <= '0;
            und_q      <= 1'b0;
            dout_q     <= 1'b0;
            area_q     <= 1'b0;
            pf_q       <= 1'b0;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_q      <= hdr_d;
            byte_q     <= byte_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            pend_q     <= pend_d;
            chk_q      <= chk_d;
            und_q      <= und_d;
            dout_q     <= dout_d;
            area_q     <= area_d;
            pf_q       <= pf_d;
            rd_en_q    <= rd_en_d;
        end
    end

    assign mem.mem_req  = req;
    assign mem.mem_addr = req ? req_addr : '0;
    assign data_out     = dout_q;
    assign data_area    = area_q;
    assign prefetch     = pf_q;
    assign underrun     = und_q;
endmodule

// File: tb/tb_sector_read_serializer.sv
// Randomized bench: a sector-level reference model queues expected per-cycle outputs,
// a monitor pops and compares them; a second small instance covers the no-checksum build.
module tb_sector_read_serializer;
    typedef struct packed {
        logic b;
        logic area;
        logic und;
        logic pfok;
    } item_t;
    typedef struct packed {
        int    e;
        item_t it;
        logic  pf;
    } exp_t;
    typedef struct {
        int         due;
        logic [7:0] d;
    } rsp_t;

    logic clk;
    int   edge_cnt;
    int   n_chk;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, edge_cnt);
        end
    endtask

    // Expected serial sequence of one sector, straight from the field definitions.
    task automatic build_sector(input int ag, input int dg, input int nb, input bit chk_en,
                                input logic [15:0] hdr, input logic [7:0] bytes[$],
                                input int wh, output item_t q[$], output logic und_end);
        logic [15:0] sum;
        logic [7:0]  b;
        logic        u;
        q   = {};
        sum = '0;
        u   = 1'b0;
        for (int k = 0; k < ag; k++) q.push_back('{logic'(k == ag - 1), 1'b0, 1'b0, 1'b1});
        for (int k = 0; k < 16; k++) q.push_back('{hdr[k], 1'b0, 1'b0, 1'b1});
        for (int k = 0; k < dg; k++) q.push_back('{logic'(k == dg - 1), 1'b0, 1'b0, 1'b0});
        for (int n = 0; n < nb; n++) begin
            if (n == wh) begin
                b = 8'h00;
                u = 1'b1;
            end else begin
                b = bytes[n];
            end
            sum = sum + 16'(b);
            for (int j = 7; j >= 0; j--) q.push_back('{b[j], 1'b1, u, 1'b0});
        end
        if (chk_en)
            for (int j = 15; j >= 0; j--) q.push_back('{sum[j], 1'b1, u, 1'b0});
        und_end = u;
    endtask

    // ---------------- instance A: default parameters ----------------
    logic        rst_a, strobe_a, rd_en_a;
    logic [1:0]  hs_a;
    logic [8:0]  cyl_a;
    logic [4:0]  sect_a;
    logic        dout_a, area_a, pf_a, und_a;

    sector_read_serializer_if #(.AW(9)) ifa ();

    sector_read_serializer dut_a (
        .clk(clk), .rst(rst_a), .hs(hs_a), .cyl(cyl_a), .sect(sect_a),
        .sector_strobe(strobe_a), .rd_en(rd_en_a), .mem(ifa),
        .data_out(dout_a), .data_area(area_a), .prefetch(pf_a), .underrun(und_a)
    );

    exp_t       expq[$];
    item_t      cur[$];
    item_t      nxt[$];
    logic       tail_und, nxt_und, rd_prev;
    bit         in_sec;
    int         idx;
    int         sid;
    logic [7:0] mem_a[$];
    int         withhold = -1;
    int         lat_mode;
    rsp_t       pend[$];
    int         rsid = -1;
    int         ridx;

    // Scoreboard monitor: one expected entry per clock edge once stimulus has started.
    always @(negedge clk) begin
        if (expq.size() > 0 && expq[0].e == edge_cnt) begin
            exp_t x;
            x = expq.pop_front();
            chk("data_out",  32'(dout_a), 32'(x.it.b));
            chk("data_area", 32'(area_a), 32'(x.it.area));
            chk("underrun",  32'(und_a),  32'(x.it.und));
            chk("prefetch",  32'(pf_a),   32'(x.pf));
        end
    end

    // Sector buffer model: answers each request after a 1..7 cycle latency.
    always @(negedge clk) begin
        int lat;
        ifa.mem_valid = 1'b0;
        ifa.mem_data  = 8'($urandom);
        if (pend.size() > 0 && pend[0].due == edge_cnt + 1) begin
            ifa.mem_valid = 1'b1;
            ifa.mem_data  = pend[0].d;
            void'(pend.pop_front());
        end
        if (ifa.mem_req === 1'b1) begin
            if (sid != rsid) begin
                rsid = sid;
                ridx = 0;
            end
            chk("a_mem_addr", 32'(ifa.mem_addr), 32'(ridx));
            lat = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 7));
            if (ridx != withhold && ridx < mem_a.size())
                pend.push_back('{due: edge_cnt + 1 + lat, d: mem_a[ridx]});
            ridx++;
        end
    end

    task automatic cyc(input bit s, input bit r);
        item_t it;
        exp_t  x;
        rst_a    = r;
        strobe_a = s;
        if ($urandom_range(0, 5) == 0) rd_en_a = !rd_en_a;
        if (r)                    it = '0;
        else if (!in_sec)         it = '{1'b0, 1'b0, 1'b0, 1'b1};
        else if (idx < cur.size()) it = cur[idx];
        else                      it = '{1'b0, 1'b1, tail_und, 1'b0};
        x.pf = !r && rd_en_a && !rd_prev && it.pfok;
        if (s) it.und = 1'b0;
        x.e  = edge_cnt + 1;
        x.it = it;
        expq.push_back(x);
        rd_prev = r ? 1'b0 : rd_en_a;
        if (r) begin
            in_sec = 1'b0;
        end else if (s) begin
            cur      = nxt;
            tail_und = nxt_und;
            idx      = 0;
            in_sec   = 1'b1;
            sid++;
        end else begin
            idx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_sector(input bit ramp, input int wh, input int lm);
        mem_a = {};
        for (int n = 0; n < 408; n++) mem_a.push_back(ramp ? 8'(n) : 8'($urandom));
        if (ramp) begin
            hs_a = 2'b01; cyl_a = 9'h1A5; sect_a = 5'd7;
        end else begin
            hs_a = 2'($urandom); cyl_a = 9'($urandom); sect_a = 5'($urandom);
        end
        withhold = wh;
        lat_mode = lm;
        build_sector(208, 208, 408, 1'b1, {hs_a, cyl_a, sect_a}, mem_a, wh, nxt, nxt_und);
        cyc(1'b1, 1'b0);
    endtask

    task automatic run_to(input int n);
        while (idx < n) cyc(1'b0, 1'b0);
    endtask

    // ---------------- instance B: no checksum, 4 bytes, short gaps ----------------
    logic        rst_b, strobe_b, dout_b, area_b, pf_b, und_b;
    logic [7:0]  bytes_b[$];
    int          reqs_b;
    int          due_b = -1;
    logic [7:0]  dat_b;
    bit          b_done;

    sector_read_serializer_if #(.AW(2)) ifb ();

    sector_read_serializer #(
        .ADDR_GAP_BITS(4), .DATA_GAP_BITS(10), .DATA_BYTES(4), .CHK_EN(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .hs(2'b10), .cyl(9'h055), .sect(5'd3),
        .sector_strobe(strobe_b), .rd_en(1'b0), .mem(ifb),
        .data_out(dout_b), .data_area(area_b), .prefetch(pf_b), .underrun(und_b)
    );

    always @(negedge clk) begin
        ifb.mem_valid = 1'b0;
        ifb.mem_data  = 8'h00;
        if (due_b == edge_cnt + 1) begin
            ifb.mem_valid = 1'b1;
            ifb.mem_data  = dat_b;
        end
        if (ifb.mem_req === 1'b1) begin
            chk("b_mem_addr", 32'(ifb.mem_addr), 32'(reqs_b));
            if (reqs_b < bytes_b.size()) dat_b = bytes_b[reqs_b];
            due_b = edge_cnt + 3;
            reqs_b++;
        end
    end

    initial begin
        item_t qb[$];
        logic  ub;
        rst_b    = 1'b1;
        strobe_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        for (int n = 0; n < 4; n++) bytes_b.push_back(8'($urandom));
        build_sector(4, 10, 4, 1'b0, {2'b10, 9'h055, 5'd3}, bytes_b, -1, qb, ub);
        strobe_b = 1'b1;
        @(posedge clk);
        #1 strobe_b = 1'b0;
        for (int k = 0; k < qb.size() + 6; k++) begin
            @(posedge clk);
            #2;
            if (k < qb.size()) begin
                chk("b_data_out",  32'(dout_b), 32'(qb[k].b));
                chk("b_data_area", 32'(area_b), 32'(qb[k].area));
            end else begin
                chk("b_end_gap_out",  32'(dout_b), 32'(0));
                chk("b_end_gap_area", 32'(area_b), 32'(1));
            end
        end
        chk("b_req_count", 32'(reqs_b), 32'(4));
        chk("b_underrun",  32'(und_b),  32'(0));
        chk("b_prefetch",  32'(pf_b),   32'(0));
        b_done = 1'b1;
    end

    // ---------------- stimulus for instance A ----------------
    initial begin
        rst_a = 1'b1; strobe_a = 1'b0; rd_en_a = 1'b0;
        hs_a = '0; cyl_a = '0; sect_a = '0;
        rd_prev = 1'b0; in_sec = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) cyc(1'b0, 1'b1);
        repeat (6) cyc(1'b0, 1'b0);

        // Ramp data at fixed latency, full sector and some end gap.
        start_sector(1'b1, -1, 3);
        run_to(cur.size() + 20);
        // Byte 5 never returned: underrun from DATA counter 40 onwards.
        start_sector(1'b0, 5, 0);
        run_to(cur.size() + 10);
        // Abort at DATA counter 100 with a response still in flight.
        start_sector(1'b0, -1, 6);
        run_to(208 + 16 + 208 + 100);
        start_sector(1'b0, -1, 0);
        run_to(cur.size() + 5);
        // Reset mid-DATA, then idle, then one more partial sector.
        start_sector(1'b0, -1, 0);
        run_to(208 + 16 + 208 + 50);
        cyc(1'b0, 1'b1);
        repeat (40) cyc(1'b0, 1'b0);
        start_sector(1'b0, -1, 0);
        run_to(600);

        strobe_a = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(expq.size()), 32'(0));
        chk("b_finished", 32'(b_done), 32'(1));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
